// File: rtl/nios_core_key_pkg.sv
// Shared constants and types for the Nios key controller: register map,
// debounce FSM encoding and the idle (released) key level.
package nios_core_key_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Keys are active-low, so an idle pin reads 1.
    localparam logic KEY_RELEASED = 1'b1;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } key_fsm_e;

endpackage

// File: rtl/nios_core_key_debounce.sv
// One key: two-flop synchroniser followed by a counting debounce FSM that
// accepts a new level only after DEBOUNCE_CYCLES consecutive stable cycles.
module nios_core_key_debounce
    import nios_core_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key,
    output logic o_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    key_fsm_e         r_fsm;
    logic             w_sync;

    assign w_sync  = r_sync[1];
    assign o_state = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= {2{KEY_RELEASED}};
            r_state <= KEY_RELEASED;
            r_cnt   <= '0;
            r_fsm   <= STABLE;
        end else begin
            r_sync <= {r_sync[0], i_key};
            case (r_fsm)
                STABLE: begin
                    if (w_sync != r_state) begin
                        r_fsm <= COUNTING;
                        r_cnt <= CNT_W'(1);
                    end
                end
                COUNTING: begin
                    // A reversion always wins over a terminal count.
                    if (w_sync == r_state) begin
                        r_fsm <= STABLE;
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= w_sync;
                        r_fsm   <= STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_fsm <= STABLE;
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/nios_core_key_ctrl.sv
// Avalon-MM key controller: per-key debounce, irq mask, W1C press capture
// and a level interrupt to the Nios interrupt controller.
module nios_core_key_ctrl
    import nios_core_key_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_state;
    logic [WIDTH-1:0] r_state_d;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_capture;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      r_readdata;
    logic [31:0]      w_rd_data;
    logic             w_wr;
    logic             w_unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_key
            nios_core_key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .i_key   (in_port[gi]),
                .o_state (w_state[gi])
            );
        end
    endgenerate

    assign w_unused_wdata = ^writedata;
    assign w_wr   = chipselect & ~write_n;
    assign w_fall = r_state_d & ~w_state;
    assign w_clr  = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_data = '0;
        case (address)
            ADDR_DATA: w_rd_data[WIDTH-1:0] = w_state;
            ADDR_MASK: w_rd_data[WIDTH-1:0] = r_mask;
            ADDR_EDGE: w_rd_data[WIDTH-1:0] = r_capture;
            default:   w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_d  <= {WIDTH{KEY_RELEASED}};
            r_mask     <= '0;
            r_capture  <= '0;
            r_readdata <= '0;
        end else begin
            r_state_d  <= w_state;
            r_readdata <= w_rd_data;
            if (w_wr && address == ADDR_MASK) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            // A press arriving with a clear on the same bit keeps the bit set.
            r_capture <= (r_capture & ~w_clr) | w_fall;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_capture & r_mask);

endmodule
